// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX pipeline stages, the divider and the hazard sequencer.
// The master modport is the sequencer side; slave is the pipeline/divider side.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_reg_w_en;
    logic [1:0] ex_mem_r;
    logic       ex_br_taken;
    logic       ex_div_valid;
    logic       div_done;
    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_stall;
    logic       idex_flush;
    logic       div_start;
    logic       div_err;
    logic       busy;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_w_en, ex_mem_r,
        input  ex_br_taken, ex_div_valid, div_done,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, div_start, div_err, busy
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_w_en, ex_mem_r,
        output ex_br_taken, ex_div_valid, div_done,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, div_start, div_err, busy
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: branch squash, load-use bubble, divide hold.
// Define HAZARD_PERF_EN to add the perf_lu_stalls / perf_div_cycles / perf_flushes counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned DIV_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    pipeline_hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]       perf_lu_stalls,
    output logic [CNT_W-1:0]       perf_div_cycles,
    output logic [CNT_W-1:0]       perf_flushes
`endif
);

    if (DIV_TIMEOUT < 2 || DIV_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
        $error("pipeline_hazard_ctrl: DIV_TIMEOUT must be 2..255 and CNT_W at least 1");
    end

    localparam logic [7:0] TimeoutLast = 8'(DIV_TIMEOUT - 1);

    typedef enum logic {StRun, StDivWait} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic load_use;
    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic div_start, div_err, busy;
    logic lu_evt, flush_evt, div_evt;

    always_comb begin
        load_use = (hz.ex_mem_r != 2'd0) && hz.ex_reg_w_en && (hz.ex_rd != 5'd0) &&
                   ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_stall = 1'b0;
        idex_flush = 1'b0;
        div_start  = 1'b0;
        div_err    = 1'b0;
        lu_evt     = 1'b0;
        flush_evt  = 1'b0;
        div_evt    = 1'b0;

        // Reset masks every output, including the divide handshake.
        if (!RESET) begin
            unique case (state_q)
                StRun: begin
                    if (hz.ex_br_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_evt  = 1'b1;
                    end else if (hz.ex_div_valid) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_stall = 1'b1;
                        div_start  = 1'b1;
                        div_evt    = 1'b1;
                        cnt_d      = 8'd0;
                        state_d    = StDivWait;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                        lu_evt     = 1'b1;
                    end
                end
                StDivWait: begin
                    div_evt = 1'b1;
                    if (hz.div_done) begin
                        state_d = StRun;
                    end else if (cnt_q == TimeoutLast) begin
                        div_err = 1'b1;
                        state_d = StRun;
                    end else begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_stall = 1'b1;
                        cnt_d      = cnt_q + 8'd1;
                    end
                end
                default: state_d = StRun;
            endcase
        end

        busy = !RESET && (state_q == StDivWait);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StRun;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.pc_stall   = pc_stall;
    assign hz.ifid_stall = ifid_stall;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_stall = idex_stall;
    assign hz.idex_flush = idex_flush;
    assign hz.div_start  = div_start;
    assign hz.div_err    = div_err;
    assign hz.busy       = busy;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

    // Counters wrap naturally at 2^CNT_W.
    always_comb begin
        lu_cnt_d  = lu_cnt_q + CNT_W'(lu_evt);
        div_cnt_d = div_cnt_q + CNT_W'(div_evt);
        fl_cnt_d  = fl_cnt_q + CNT_W'(flush_evt);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lu_cnt_q  <= '0;
            div_cnt_q <= '0;
            fl_cnt_q  <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            div_cnt_q <= div_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
        end
    end

    assign perf_lu_stalls  = lu_cnt_q;
    assign perf_div_cycles = div_cnt_q;
    assign perf_flushes    = fl_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded bench for pipeline_hazard_ctrl (DIV_TIMEOUT=8); covers perf counters when
// HAZARD_PERF_EN is defined.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       dv;
        logic       dd;
        logic [1:0] mem_r;
        logic       wen;
        logic [4:0] rd;
        logic       u1;
        logic [4:0] rs1;
        logic       u2;
        logic [4:0] rs2;
    } stim_t;

    // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    //                       div_start, div_err, busy}
    localparam logic [7:0] ONone  = 8'b0000_0000;
    localparam logic [7:0] OLu    = 8'b1100_1000;
    localparam logic [7:0] OBr    = 8'b0010_1000;
    localparam logic [7:0] OStart = 8'b1101_0100;
    localparam logic [7:0] OWait  = 8'b1101_0001;
    localparam logic [7:0] ODone  = 8'b0000_0001;
    localparam logic [7:0] OErr   = 8'b0000_0011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_stalls, perf_div_cycles, perf_flushes;
`endif

    pipeline_hazard_ctrl #(
        .DIV_TIMEOUT(8),
        .CNT_W      (32)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .hz   (hz.master)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_stalls (perf_lu_stalls),
        .perf_div_cycles(perf_div_cycles),
        .perf_flushes   (perf_flushes)
`endif
    );

    wire [7:0] outs = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
                       hz.idex_flush, hz.div_start, hz.div_err, hz.busy};

    function automatic stim_t mk(input logic r, input logic br, input logic dv, input logic dd,
                                 input logic [1:0] mem_r, input logic wen, input logic [4:0] rd,
                                 input logic u1, input logic [4:0] rs1, input logic u2,
                                 input logic [4:0] rs2);
        stim_t s;
        s = '{rst: r, br: br, dv: dv, dd: dd, mem_r: mem_r, wen: wen, rd: rd,
              u1: u1, rs1: rs1, u2: u2, rs2: rs2};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        rst             = s.rst;
        hz.ex_br_taken  = s.br;
        hz.ex_div_valid = s.dv;
        hz.div_done     = s.dd;
        hz.ex_mem_r     = s.mem_r;
        hz.ex_reg_w_en  = s.wen;
        hz.ex_rd        = s.rd;
        hz.id_use_rs1   = s.u1;
        hz.id_rs1       = s.rs1;
        hz.id_use_rs2   = s.u2;
        hz.id_rs2       = s.rs2;
    endtask

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    endfunction

    function automatic stim_t lu_hit(input logic r, input logic br, input logic dv,
                                     input logic dd);
        return mk(r, br, dv, dd, 2'd1, 1, 5'd5, 0, 5'd0, 1, 5'd5);
    endfunction

    task automatic test_reset();
        stim_t st [2];
        logic [7:0] ex [2];
        logic [7:0] got, exp;
        st[0] = lu_hit(1, 1, 0, 0); ex[0] = ONone;
        st[1] = lu_hit(1, 0, 1, 1); ex[1] = ONone;
        for (int i = 0; i < 2; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = outs;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL reset[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st [8];
        logic [7:0] ex [8];
        logic [7:0] got, exp;
        st[0] = lu_hit(0, 0, 0, 0);                              ex[0] = OLu;
        st[1] = idle();                                          ex[1] = ONone;
        st[2] = mk(0, 0, 0, 0, 2'd1, 1, 5'd0, 0, 5'd0, 1, 5'd0); ex[2] = ONone;
        st[3] = mk(0, 0, 0, 0, 2'd2, 1, 5'd9, 1, 5'd9, 0, 5'd3); ex[3] = OLu;
        st[4] = mk(0, 0, 0, 0, 2'd2, 1, 5'd9, 0, 5'd9, 0, 5'd3); ex[4] = ONone;
        st[5] = mk(0, 0, 0, 0, 2'd0, 1, 5'd5, 0, 5'd0, 1, 5'd5); ex[5] = ONone;
        st[6] = mk(0, 0, 0, 0, 2'd1, 0, 5'd5, 0, 5'd0, 1, 5'd5); ex[6] = ONone;
        st[7] = mk(0, 0, 0, 1, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[7] = ONone;
        for (int i = 0; i < 8; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = outs;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL load_use[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_branch();
        stim_t st [4];
        logic [7:0] ex [4];
        logic [7:0] got, exp;
        st[0] = lu_hit(0, 1, 0, 0); ex[0] = OBr;
        st[1] = lu_hit(0, 1, 1, 0); ex[1] = OBr;
        st[2] = idle();             ex[2] = ONone;
        st[3] = lu_hit(0, 0, 0, 0); ex[3] = OLu;
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = outs;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL branch[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    // Divide with done in DIV_WAIT cycle 3, then an immediate second divide done in cycle 1.
    task automatic test_back_to_back();
        stim_t st [7];
        logic [7:0] ex [7];
        logic [7:0] got, exp;
        st[0] = mk(0, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[0] = OStart;
        st[1] = mk(0, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[1] = OWait;
        st[2] = lu_hit(0, 1, 1, 0);                              ex[2] = OWait;
        st[3] = mk(0, 0, 1, 1, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[3] = ODone;
        st[4] = mk(0, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[4] = OStart;
        st[5] = mk(0, 0, 1, 1, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[5] = ODone;
        st[6] = idle();                                          ex[6] = ONone;
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = outs;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL divide[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t dv_s;
        logic [7:0] got, exp;
        dv_s = mk(0, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            apply((i == 9) ? idle() : dv_s);
            if (i == 0)      exp_q.push_back(OStart);
            else if (i < 8)  exp_q.push_back(OWait);
            else if (i == 8) exp_q.push_back(OErr);
            else             exp_q.push_back(ONone);
            @(negedge clk);
            got = outs;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL timeout[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        stim_t st [5];
        logic [7:0] ex [5];
        logic [7:0] got, exp;
        st[0] = mk(0, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[0] = OStart;
        st[1] = mk(0, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[1] = OWait;
        st[2] = mk(1, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[2] = ONone;
        st[3] = mk(0, 0, 0, 1, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); ex[3] = ONone;
        st[4] = idle();                                          ex[4] = ONone;
        for (int i = 0; i < 5; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = outs;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL reset_mid_div[%0d] got=%b expected=%b", i, got, exp);
            end
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        stim_t st [10];
        logic [7:0] got, exp;
        st[0] = mk(1, 0, 0, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        st[1] = lu_hit(0, 0, 0, 0);
        st[2] = idle();
        st[3] = lu_hit(0, 0, 0, 0);
        st[4] = lu_hit(0, 1, 0, 0);
        st[5] = mk(0, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        st[6] = mk(0, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        st[7] = mk(0, 0, 1, 0, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        st[8] = mk(0, 0, 1, 1, 2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        st[9] = idle();
        for (int i = 0; i < 10; i++) begin
            apply(st[i]);
            @(negedge clk);
            if (i == 1) begin
                n_checks++;
                if ({perf_lu_stalls, perf_div_cycles, perf_flushes} !== 96'd0) begin
                    n_errors++;
                    $display("FAIL perf_clear got=%0d/%0d/%0d expected=0/0/0",
                             perf_lu_stalls, perf_div_cycles, perf_flushes);
                end
            end
        end
        exp_q.push_back(ONone);
        got = outs;
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL perf_idle got=%b expected=%b", got, exp);
        end
        n_checks++;
        if (perf_lu_stalls !== 32'd2) begin
            n_errors++;
            $display("FAIL perf_lu_stalls got=%0d expected=2", perf_lu_stalls);
        end
        n_checks++;
        if (perf_flushes !== 32'd1) begin
            n_errors++;
            $display("FAIL perf_flushes got=%0d expected=1", perf_flushes);
        end
        n_checks++;
        if (perf_div_cycles !== 32'd4) begin
            n_errors++;
            $display("FAIL perf_div_cycles got=%0d expected=4", perf_div_cycles);
        end
    endtask
`endif

    initial begin
        hz.ex_br_taken  = 1'b0;
        hz.ex_div_valid = 1'b0;
        hz.div_done     = 1'b0;
        hz.ex_mem_r     = 2'd0;
        hz.ex_reg_w_en  = 1'b0;
        hz.ex_rd        = 5'd0;
        hz.id_use_rs1   = 1'b0;
        hz.id_rs1       = 5'd0;
        hz.id_use_rs2   = 1'b0;
        hz.id_rs2       = 5'd0;
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_reset_mid_div();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
